hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 16-bit RISC core. It generates the stall (dhazard) and flush (chazard) controls consumed by the IF/ID decode pipe register, plus PC-hold and EX-bubble controls. It sequences multi-cycle load-use stalls and multi-cycle branch flushes with a small FSM, freezes the front end during memory wait, and keeps saturating hazard statistics.

---
 rtl/hazard_ctrl_if.sv | 38 +++
 rtl/hazard_ctrl.sv | 107 ++++++++++
 tb/tb_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline and its hazard controller.
// master = pipeline side (drives hazard sources), slave = hazard_ctrl.
interface hazard_ctrl_if #(
  parameter int REG_BITS = 3,
  parameter int CNT_W    = 16
);
  logic                id_valid;
  logic [REG_BITS-1:0] id_rs1;
  logic [REG_BITS-1:0] id_rs2;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic                ex_is_load;
  logic [REG_BITS-1:0] ex_rd;
  logic                branch_taken;
  logic                mem_busy;
  logic                stat_clr;
  logic                dhazard;
  logic                chazard;
  logic                pc_hold;
  logic                ex_bubble;
  logic [1:0]          fsm_state;
  logic [CNT_W-1:0]    stall_cycles;
  logic [CNT_W-1:0]    flush_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_is_load, ex_rd, branch_taken, mem_busy, stat_clr,
    input  dhazard, chazard, pc_hold, ex_bubble, fsm_state,
           stall_cycles, flush_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_is_load, ex_rd, branch_taken, mem_busy, stat_clr,
    output dhazard, chazard, pc_hold, ex_bubble, fsm_state,
           stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 16-bit RISC pipeline: load-use stalls, branch
// flushes, memory-wait freeze, and saturating per-cycle hazard statistics.
module hazard_ctrl #(
  parameter int REG_BITS     = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);
  localparam int MAX_LAT = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] LOAD_RELOAD  = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0] FLUSH_RELOAD = CW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic             load_use;
  logic             flush_now;
  logic             stall_now;
  logic             dh;
  logic             ch;
  logic [1:0]       hit;
  logic [CNT_W-1:0] stat_reg [2];

  always_comb begin
    load_use  = hz.id_valid && hz.ex_is_load && (hz.ex_rd != '0) &&
                ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                 (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
    // A taken branch wins over an ongoing stall; FLUSH ignores load-use.
    flush_now = !hz.mem_busy && (hz.branch_taken || (state_reg == FLUSH));
    stall_now = !hz.mem_busy && !flush_now &&
                ((state_reg == STALL) || ((state_reg == RUN) && load_use));
  end

  // Controls are gated by reset so they drop the instant reset asserts.
  assign dh = reset && (hz.mem_busy || stall_now);
  assign ch = reset && flush_now;

  assign hz.dhazard      = dh;
  assign hz.pc_hold      = dh;
  assign hz.chazard      = ch;
  assign hz.ex_bubble    = reset && (flush_now || stall_now);
  assign hz.fsm_state    = state_reg;
  assign hz.stall_cycles = stat_reg[0];
  assign hz.flush_cycles = stat_reg[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= RUN;
      count_reg <= '0;
    end else begin
      case (state_reg)
        RUN, STALL, FLUSH: begin
          if (!hz.mem_busy) begin
            if (hz.branch_taken) begin
              if (FLUSH_CYCLES > 1) begin
                state_reg <= FLUSH;
                count_reg <= FLUSH_RELOAD;
              end else begin
                state_reg <= RUN;
                count_reg <= '0;
              end
            end else if (state_reg != RUN) begin
              // count holds the remaining STALL/FLUSH cycles including this one
              if (count_reg <= CW'(1)) begin
                state_reg <= RUN;
                count_reg <= '0;
              end else begin
                count_reg <= count_reg - CW'(1);
              end
            end else if (load_use && (LOAD_LAT > 1)) begin
              state_reg <= STALL;
              count_reg <= LOAD_RELOAD;
            end
          end
        end
        default: begin
          state_reg <= RUN;
          count_reg <= '0;
        end
      endcase
    end
  end

  assign hit = {ch, dh};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stat_reg[gi] <= '0;
      end else if (hz.stat_clr) begin
        stat_reg[gi] <= '0;
      end else if (hit[gi] && (stat_reg[gi] != '1)) begin
        stat_reg[gi] <= stat_reg[gi] + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Two hazard_ctrl instances (L=2/F=3/16-bit stats and L=3/F=1/4-bit stats)
// share one stimulus stream and are checked against a remaining-cycles model.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_BITS(3), .CNT_W(16)) if_a ();
  hazard_ctrl_if #(.REG_BITS(3), .CNT_W(4))  if_b ();

  hazard_ctrl #(.REG_BITS(3), .LOAD_LAT(2), .FLUSH_CYCLES(3), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .hz(if_a));
  hazard_ctrl #(.REG_BITS(3), .LOAD_LAT(3), .FLUSH_CYCLES(1), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset), .hz(if_b));

  assign if_b.id_valid     = if_a.id_valid;
  assign if_b.id_rs1       = if_a.id_rs1;
  assign if_b.id_rs2       = if_a.id_rs2;
  assign if_b.id_use_rs1   = if_a.id_use_rs1;
  assign if_b.id_use_rs2   = if_a.id_use_rs2;
  assign if_b.ex_is_load   = if_a.ex_is_load;
  assign if_b.ex_rd        = if_a.ex_rd;
  assign if_b.branch_taken = if_a.branch_taken;
  assign if_b.mem_busy     = if_a.mem_busy;
  assign if_b.stat_clr     = if_a.stat_clr;

  logic [3:0]  ctl [2];
  logic [1:0]  fs  [2];
  logic [15:0] sc  [2];
  logic [15:0] fc  [2];
  assign ctl[0] = {if_a.dhazard, if_a.chazard, if_a.pc_hold, if_a.ex_bubble};
  assign ctl[1] = {if_b.dhazard, if_b.chazard, if_b.pc_hold, if_b.ex_bubble};
  assign fs[0]  = if_a.fsm_state;
  assign fs[1]  = if_b.fsm_state;
  assign sc[0]  = if_a.stall_cycles;
  assign sc[1]  = {12'd0, if_b.stall_cycles};
  assign fc[0]  = if_a.flush_cycles;
  assign fc[1]  = {12'd0, if_b.flush_cycles};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: remaining stall/flush cycles after the current one.
  int lat_l [2] = '{2, 3};
  int lat_f [2] = '{3, 1};
  int maxv  [2] = '{65535, 15};
  int rem_s [2];
  int rem_f [2];
  int m_st  [2];
  int m_fl  [2];
  logic [3:0] smp_ctl [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      rem_s[k] = 0; rem_f[k] = 0; m_st[k] = 0; m_fl[k] = 0;
    end
  endtask

  function automatic logic [3:0] exp_ctrl(input int k, input logic lu, input logic br, input logic mb);
    if (mb) return 4'b1010;
    if (br || rem_f[k] > 0) return 4'b0101;
    if (rem_s[k] > 0 || lu) return 4'b1011;
    return 4'b0000;
  endfunction

  task automatic model_update(input int k, input logic lu, input logic [3:0] e);
    if (if_a.stat_clr) begin
      m_st[k] = 0; m_fl[k] = 0;
    end else begin
      if (e[3] && m_st[k] < maxv[k]) m_st[k]++;
      if (e[2] && m_fl[k] < maxv[k]) m_fl[k]++;
    end
    if (!if_a.mem_busy) begin
      if (if_a.branch_taken) begin
        rem_f[k] = lat_f[k] - 1; rem_s[k] = 0;
      end else if (rem_f[k] > 0) rem_f[k]--;
      else if (rem_s[k] > 0) rem_s[k]--;
      else if (lu) rem_s[k] = lat_l[k] - 1;
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic u1, input logic u2, input logic ld, input logic [2:0] rd,
                       input logic br, input logic mb, input logic clr);
    if_a.id_valid = v; if_a.id_rs1 = rs1; if_a.id_rs2 = rs2;
    if_a.id_use_rs1 = u1; if_a.id_use_rs2 = u2; if_a.ex_is_load = ld;
    if_a.ex_rd = rd; if_a.branch_taken = br; if_a.mem_busy = mb; if_a.stat_clr = clr;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // One clock cycle: check combinational controls, clock, check registered state.
  task automatic step();
    logic lu;
    logic [3:0] e [2];
    #1;
    lu = if_a.id_valid && if_a.ex_is_load && (if_a.ex_rd != 3'd0) &&
         ((if_a.id_use_rs1 && if_a.id_rs1 == if_a.ex_rd) ||
          (if_a.id_use_rs2 && if_a.id_rs2 == if_a.ex_rd));
    for (int k = 0; k < 2; k++) begin
      e[k] = exp_ctrl(k, lu, if_a.branch_taken, if_a.mem_busy);
      smp_ctl[k] = ctl[k];
      chk($sformatf("ctl%0d", k), 32'(ctl[k]), 32'(e[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k, lu, e[k]);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("fsm%0d", k), 32'(fs[k]),
          (rem_f[k] > 0) ? 32'd2 : ((rem_s[k] > 0) ? 32'd1 : 32'd0));
      chk($sformatf("stall_cnt%0d", k), 32'(sc[k]), 32'(m_st[k]));
      chk($sformatf("flush_cnt%0d", k), 32'(fc[k]), 32'(m_fl[k]));
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic v; logic [2:0] rs1; logic [2:0] rs2; logic u1; logic u2; logic ld;
    logic [2:0] rd; logic br; logic mb; logic [3:0] ctl; logic [1:0] st;
  } vec_t;
  vec_t tab [13];

  initial begin
    int n;
    // Expectations for instance a (LOAD_LAT=2, FLUSH_CYCLES=3); ctl = {dh,ch,pc,bub}
    tab[0]  = '{1, 0, 3, 0, 1, 1, 3, 0, 0, 4'b1011, 2'd1}; // load-use via rs2
    tab[1]  = '{1, 0, 3, 0, 1, 1, 3, 0, 0, 4'b1011, 2'd0}; // second stall cycle
    tab[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'd0};
    tab[3]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 4'b0000, 2'd0}; // r0 never hazards
    tab[4]  = '{1, 0, 3, 0, 1, 1, 3, 1, 0, 4'b0101, 2'd2}; // branch beats load-use
    tab[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0101, 2'd2};
    tab[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0101, 2'd0};
    tab[7]  = '{1, 0, 3, 0, 1, 1, 3, 1, 1, 4'b1010, 2'd0}; // mem_busy beats all
    tab[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'd0};
    tab[9]  = '{1, 5, 0, 1, 0, 1, 5, 0, 0, 4'b1011, 2'd1}; // load-use via rs1
    tab[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1010, 2'd1}; // freeze inside STALL
    tab[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1011, 2'd0};
    tab[12] = '{1, 5, 0, 0, 0, 1, 5, 0, 0, 4'b0000, 2'd0}; // reg match but unused

    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ctl%0d", k), 32'(ctl[k]), 32'd0);
      chk($sformatf("rst_fsm%0d", k), 32'(fs[k]), 32'd0);
      chk($sformatf("rst_cnt%0d", k), {sc[k], fc[k]}, 32'd0);
    end
    model_reset();
    reset = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      drive(tab[i].v, tab[i].rs1, tab[i].rs2, tab[i].u1, tab[i].u2, tab[i].ld,
            tab[i].rd, tab[i].br, tab[i].mb, 1'b0);
      step();
      chk($sformatf("vec%0d_ctl", i), 32'(smp_ctl[0]), 32'(tab[i].ctl));
      chk($sformatf("vec%0d_fsm", i), 32'(fs[0]), 32'(tab[i].st));
    end

    // Single branch pulse then a pulse on the last flush cycle (instance a).
    for (int p = 0; p < 2; p++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
      n = 0;
      for (int i = 0; i < 12; i++) begin
        drive(0, 0, 0, 0, 0, 0, 0, (i == 0) || (p == 1 && i == 2), 0, 0);
        step();
        if (smp_ctl[0][2]) n++;
        chk($sformatf("flush_no_dh_p%0d_%0d", p, i), 32'(smp_ctl[0][3]), 32'd0);
      end
      chk($sformatf("flush_len_p%0d", p), n, (p == 0) ? 32'd3 : 32'd5);
      chk($sformatf("flush_stat_p%0d", p), 32'(fc[0]), (p == 0) ? 32'd3 : 32'd5);
    end

    // Freeze four cycles inside a LOAD_LAT=3 stall (instance b).
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) drive(1, 2, 0, 1, 0, 1, 2, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0, 0, (i >= 1 && i <= 4), 0);
      step();
      if (smp_ctl[1][3]) n++;
    end
    chk("freeze_len", n, 32'd7);
    chk("freeze_stat", 32'(sc[1]), 32'd7);

    // Saturation of the 4-bit counters, then clear while dhazard is high.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); step();
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
    end
    chk("sat_b", 32'(sc[1]), 32'd15);
    chk("nosat_a", 32'(sc[0]), 32'd20);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); step();
    chk("clr_b", 32'(sc[1]), 32'd0);
    chk("clr_a", 32'(sc[0]), 32'd0);

    // Asynchronous reset in the middle of a flush with branch_taken held.
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ctl", 32'(ctl[0]), 32'd0);
    chk("midrst_fsm", 32'(fs[0]), 32'd0);
    chk("midrst_cnt", {sc[0], fc[0]}, 32'd0);
    model_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    repeat (3) step();

    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 3)), $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 31) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
